// File: rtl/tokenflow_gen.sv
// Token generator driving a 4-phase req/ack channel with a folded value of
// one of four integer sequences; ack_in arrives asynchronously from a pad.
module tokenflow_gen #(
  parameter int W           = 26,
  parameter int OUT_W       = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [1:0]       mode,
  input  logic             ack_in,
  output logic             req,
  output logic [OUT_W-1:0] data_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RET  = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   ack_s;
  state_t                 state_r;
  logic [W-1:0]           x_r;
  logic [W-1:0]           v_r;
  logic [1:0]             mode_q_r;
  logic                   req_r;
  logic [OUT_W-1:0]       data_r;
  logic [W-1:0]           x_plus1_s;
  logic [W-1:0]           adv_s;

  // Upper bits folded onto the low OUT_W bits; the high part never exceeds OUT_W bits.
  function automatic logic [OUT_W-1:0] fold(input logic [W-1:0] val);
    logic [W-1:0] hi;
    hi = val >> OUT_W;
    return val[OUT_W-1:0] ^ hi[OUT_W-1:0];
  endfunction

  // Synchronizer chain for the pad-driven acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign ack_s     = sync_r[SYNC_STAGES-1];
  assign x_plus1_s = x_r + ONE;

  // Per-mode step added to v, based on the pre-increment counter x.
  always_comb begin
    adv_s = {W{1'b0}};
    case (mode_q_r)
      2'b00:   adv_s = x_plus1_s + x_plus1_s;
      2'b01:   adv_s = ONE;
      2'b10:   adv_s = x_r + x_r + ONE;
      2'b11:   adv_s = x_plus1_s;
      default: adv_s = {W{1'b0}};
    endcase
  end

  // Handshake FSM with sequence state and registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      x_r      <= {W{1'b0}};
      v_r      <= {W{1'b0}};
      mode_q_r <= 2'b00;
      req_r    <= 1'b0;
      data_r   <= {OUT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          req_r <= 1'b0;
          if (run && !ack_s) begin
            state_r <= REQ;
            req_r   <= 1'b1;
            // A new mode restarts its sequence, so the token is fold(0) = 0.
            if (mode != mode_q_r) begin
              x_r      <= {W{1'b0}};
              v_r      <= {W{1'b0}};
              mode_q_r <= mode;
              data_r   <= {OUT_W{1'b0}};
            end else begin
              data_r <= fold(v_r);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (ack_s) begin
            state_r <= RET;
            req_r   <= 1'b0;
            v_r     <= v_r + adv_s;
            x_r     <= x_plus1_s;
          end else begin
            state_r <= REQ;
            req_r   <= 1'b1;
          end
        end
        RET: begin
          req_r <= 1'b0;
          if (!ack_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= RET;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign req      = req_r;
  assign data_out = data_r;

endmodule

// File: tb/tb_tokenflow_gen.sv
// Directed bench for tokenflow_gen: default-width instance plus a narrow
// W=8/OUT_W=4 instance used for the wrap-around run.
module tb_tokenflow_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run0, run1;
  logic [1:0]  mode0, mode1;
  logic        ack_tie, ack_man;
  logic        ack0, ack1;
  logic        req0, req1;
  logic [14:0] d0;
  logic [3:0]  d1;
  int          checks = 0;
  int          errors = 0;
  int          rises1 = 0;
  logic        req1_d = 1'b0;

  always #5 clk = ~clk;

  assign ack0 = ack_tie ? req0 : ack_man;
  assign ack1 = req1;

  tokenflow_gen dut0 (
    .clk(clk), .rst_n(rst_n), .run(run0), .mode(mode0),
    .ack_in(ack0), .req(req0), .data_out(d0)
  );

  tokenflow_gen #(.W(8), .OUT_W(4), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .mode(mode1),
    .ack_in(ack1), .req(req1), .data_out(d1)
  );

  // Count rising edges of the narrow instance's request.
  always @(negedge clk) begin
    if (req1 && !req1_d) rises1 <= rises1 + 1;
    req1_d <= req1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for req edge", tag);
  endtask

  task automatic wait_req0(input logic val, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (req0 === val) hit = 1'b1;
    end
    if (!hit) timeout(tag);
  endtask

  task automatic wait_req1(input logic val, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (req1 === val) hit = 1'b1;
    end
    if (!hit) timeout(tag);
  endtask

  task automatic token0(input string tag, input int exp);
    wait_req0(1'b1, tag);
    check(tag, int'(d0), exp);
    wait_req0(1'b0, tag);
  endtask

  task automatic token1(input string tag, input int exp);
    wait_req1(1'b1, tag);
    check(tag, int'(d1), exp);
    wait_req1(1'b0, tag);
  endtask

  task automatic do_reset();
    run0  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int seq00 [6] = '{0, 2, 6, 12, 20, 30};
    int seqm  [3][4] = '{'{0, 1, 2, 3}, '{0, 1, 4, 9}, '{0, 1, 3, 6}};
    bit stay;
    int v;

    rst_n = 1'b0; run0 = 1'b0; run1 = 1'b0;
    mode0 = 2'b00; mode1 = 2'b01;
    ack_tie = 1'b1; ack_man = 1'b0;
    #1;
    check("reset_req0", int'(req0), 0);
    check("reset_data0", int'(d0), 0);
    check("reset_req1", int'(req1), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 00 from reset: x(x+1)
    run0 = 1'b1;
    foreach (seq00[i]) token0("mode00_seq", seq00[i]);

    // Modes 01, 10, 11, each from reset
    for (int m = 1; m < 4; m++) begin
      do_reset();
      mode0 = 2'(m);
      run0  = 1'b1;
      for (int k = 0; k < 4; k++) token0("mode_seq", seqm[m-1][k]);
    end

    // Switching 10 -> 01 restarts the sequence
    do_reset();
    mode0 = 2'b10;
    run0  = 1'b1;
    token0("switch_pre", 0);
    token0("switch_pre", 1);
    token0("switch_pre", 4);
    mode0 = 2'b01;
    token0("switch_post", 0);
    token0("switch_post", 1);

    // Fold of v = 2^15 + 5 gives 5 ^ 1 = 4
    do_reset();
    mode0 = 2'b00;
    repeat (3) @(negedge clk);
    force dut0.v_r = 26'd32773;
    @(negedge clk);
    run0 = 1'b1;
    wait_req0(1'b1, "fold_req");
    check("fold_value", int'(d0), 4);
    release dut0.v_r;
    run0 = 1'b0;
    wait_req0(1'b0, "fold_done");
    repeat (6) @(negedge clk);

    // Reset while req is high aborts the handshake
    do_reset();
    mode0 = 2'b00;
    run0  = 1'b1;
    token0("midrst_pre", 0);
    token0("midrst_pre", 2);
    wait_req0(1'b1, "midrst_req");
    check("midrst_data", int'(d0), 6);
    rst_n = 1'b0;
    #1;
    check("midrst_req_low", int'(req0), 0);
    check("midrst_data_clr", int'(d0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    token0("midrst_first", 0);
    token0("midrst_second", 2);

    // Stale ack held high across reset release blocks issue
    run0 = 1'b0;
    repeat (6) @(negedge clk);
    ack_tie = 1'b0;
    ack_man = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("stale_rst_req", int'(req0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run0 = 1'b1;
    stay = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (req0 !== 1'b0) stay = 1'b0;
    end
    check("stale_hold", int'(stay), 1);
    ack_man = 1'b0;
    wait_req0(1'b1, "stale_release");
    check("stale_token", int'(d0), 0);
    ack_tie = 1'b1;
    wait_req0(1'b0, "stale_done");

    // Dropping run mid-handshake lets it complete, then no new req
    wait_req0(1'b1, "rundrop_req");
    check("rundrop_data", int'(d0), 2);
    run0 = 1'b0;
    wait_req0(1'b0, "rundrop_complete");
    stay = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (req0 !== 1'b0) stay = 1'b0;
    end
    check("rundrop_idle", int'(stay), 1);
    run0 = 1'b1;
    token0("rundrop_resume", 6);
    run0 = 1'b0;

    // Narrow instance, mode 01: v wraps at 256, token 256 folds to 0
    run1 = 1'b1;
    for (int k = 0; k < 257; k++) begin
      v = k % 256;
      token1("wrap_seq", (v & 15) ^ (v >> 4));
    end
    run1 = 1'b0;
    repeat (10) @(negedge clk);
    check("wrap_req_rises", rises1, 257);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tokenflow_gen.md
TOKENFLOW_GEN -- requirements
Module: tokenflow_gen

Interface
REQ-001 Parameter W, default 26, SHALL set the internal sequence-value width in bits.
REQ-002 Parameter OUT_W, default 15, SHALL set the folded output width; legal range OUT_W < W <= 2*OUT_W.
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set the ack synchronizer depth; legal range >= 2.
REQ-004 One clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 run  input  1  enables issue of new tokens; synchronous to clk.
REQ-008 mode  input  2  sequence select; synchronous to clk.
REQ-009 ack_in  input  1  4-phase channel acknowledge; asynchronous to clk (driven from pad).
REQ-010 req  output  1  4-phase channel request; registered.
REQ-011 data_out  output  OUT_W  folded token value; registered, bundled with req.

Function
REQ-012 ack_in SHALL pass through a SYNC_STAGES flop chain reset to 0; the last stage is ack_s, and no logic SHALL use ack_in directly.
REQ-013 State SHALL comprise a W-bit counter x, a W-bit value v, a latched 2-bit mode_q and an FSM with states IDLE, REQ, RET.
REQ-014 IDLE: req=0; when run=1 and ack_s=0, go to REQ, with req=1 on the next rising edge.
REQ-015 On the IDLE->REQ edge, if mode != mode_q, x and v SHALL clear to 0 and mode_q SHALL load mode; otherwise x and v are unchanged.
REQ-016 On that same edge, data_out SHALL load fold(v), using the value after any clear from REQ-015.
REQ-017 fold(v) = v[OUT_W-1:0] XOR (v >> OUT_W) zero-extended to OUT_W bits.
REQ-018 REQ: req=1 and data_out held stable; when ack_s=1, go to RET, with req=0 on the next edge.
REQ-019 On the REQ->RET edge, v SHALL advance by mode_q, using the pre-increment x, and x SHALL increment by 1.
REQ-020 Advance rules: 00 v+=2(x+1) (x(x+1)); 01 v+=1 (x); 10 v+=2x+1 (x^2); 11 v+=x+1 (x(x+1)/2).
REQ-021 All arithmetic SHALL be modulo 2^W; x and v wrap silently with no flag.
REQ-022 RET: req=0; when ack_s=0, go to IDLE.
REQ-023 A full handshake SHALL take at least 3 + 2*SYNC_STAGES clk cycles when ack_in mirrors req.
REQ-024 run=0 SHALL only block the IDLE->REQ transition; an in-flight handshake SHALL complete.
REQ-025 mode changes outside the IDLE->REQ edge SHALL have no effect.
REQ-026 With ack_s=1 in IDLE (stale ack), the FSM SHALL stay in IDLE until ack_s=0.
REQ-027 data_out SHALL change only on the IDLE->REQ edge or on reset.

Reset
REQ-028 rst_n=0 SHALL immediately and asynchronously force req=0, data_out=0, x=0, v=0, mode_q=00, FSM=IDLE and all synchronizer flops=0.
REQ-029 Reset asserted mid-handshake SHALL abort it; the first token after release SHALL carry data_out=0.
REQ-030 The first token after reset SHALL be 0 in every mode.

Verification
REQ-031 Defaults; mode=00, run=1, ack_in tied to req -> data_out sequence 0,2,6,12,20,30.
REQ-032 Modes 01/10/11, each from reset -> sequences 0,1,2,3 / 0,1,4,9 / 0,1,3,6; switching 10->01 after three tokens -> next tokens 0,1.
REQ-033 Force v to 2^15+5 (W=26, OUT_W=15) -> data_out=4 while req=1.
REQ-034 W=8, OUT_W=4, mode=01, 257 tokens -> token 256 has data_out=0, and req never glitches.
REQ-035 Pulse rst_n low while req=1 -> req=0 within the same cycle; after release the first token is 0. Separately, hold ack_in=1 at reset release -> req stays 0 until ack_in=0.
REQ-036 Drop run=0 while req=1 -> the handshake completes and no further req rises until run=1.
